mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: launches one data-bus transaction per op, stalls the pipeline until it completes, and times out.
// Optional MEM_ALIGN_CHECK_EN raises AdelM/AdesM for misaligned half/word accesses instead of launching them.
module mem_access_unit #(
  parameter int LAT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  input  logic        FlushM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        AdelM,
  output logic        AdesM,
  output logic        BusErrM,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [3:0]  dbe,
  output logic [31:0] dwdata,
  input  logic        dack,
  input  logic [31:0] drdata
);

  localparam int CNT_W = $clog2(LAT_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        daddr_q, daddr_d;
  logic [3:0]         dbe_q, dbe_d;
  logic               dwe_q, dwe_d;
  logic [31:0]        dwdata_q, dwdata_d;
  logic [1:0]         ld_size_q, ld_size_d;
  logic               ld_signed_q, ld_signed_d;
  logic [1:0]         ld_lane_q, ld_lane_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               bus_err_q, bus_err_d;

  logic               misaligned;
  logic               op_valid;
  logic               timeout;
  logic [3:0]         be_new;
  logic [31:0]        wdata_new;

  function automatic logic [31:0] load_extract(input logic [31:0] d,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [31:0]        sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    sh  = d >> {lane, 3'b000};
    b_s = sh[7:0];
    h_s = lane[1] ? d[31:16] : d[15:0];
    case (size)
      2'b00:   load_extract = sgn ? 32'(b_s) : {24'b0, b_s};
      2'b01:   load_extract = sgn ? 32'(h_s) : {16'b0, h_s};
      default: load_extract = d;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((MemSizeM == 2'b01) & AddrM[0]) | (MemSizeM[1] & (AddrM[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign op_valid = (MemReadM | MemWriteM) & ~FlushM & ~misaligned;
  // Timeout fires on the LAT_LIMIT-th BUSY cycle; a dack in that same cycle takes priority.
  assign timeout  = (state_q == S_BUSY) & ~dack & (cnt_q == CNT_W'(LAT_LIMIT - 1));

  always_comb begin
    case (MemSizeM)
      2'b00: begin
        be_new    = 4'b0001 << AddrM[1:0];
        wdata_new = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {AddrM[1], 1'b0};
        wdata_new = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = WriteDataM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      daddr_q     <= '0;
      dbe_q       <= '0;
      dwe_q       <= 1'b0;
      dwdata_q    <= '0;
      ld_size_q   <= '0;
      ld_signed_q <= 1'b0;
      ld_lane_q   <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      daddr_q     <= daddr_d;
      dbe_q       <= dbe_d;
      dwe_q       <= dwe_d;
      dwdata_q    <= dwdata_d;
      ld_size_q   <= ld_size_d;
      ld_signed_q <= ld_signed_d;
      ld_lane_q   <= ld_lane_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_valid) state_d = S_BUSY;
      S_BUSY:  if (dack || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    daddr_d     = daddr_q;
    dbe_d       = dbe_q;
    dwe_d       = dwe_q;
    dwdata_d    = dwdata_q;
    ld_size_d   = ld_size_q;
    ld_signed_d = ld_signed_q;
    ld_lane_d   = ld_lane_q;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    if (state_q == S_IDLE && op_valid) begin
      cnt_d       = '0;
      daddr_d     = {AddrM[31:2], 2'b00};
      dbe_d       = be_new;
      dwe_d       = MemWriteM;
      dwdata_d    = wdata_new;
      ld_size_d   = MemSizeM;
      ld_signed_d = MemSignedM;
      ld_lane_d   = AddrM[1:0];
    end else if (state_q == S_BUSY) begin
      if (dack) begin
        if (!dwe_q) rdata_d = load_extract(drdata, ld_size_q, ld_lane_q, ld_signed_q);
      end else if (timeout) begin
        rdata_d   = '0;
        bus_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    dreq   = (state_q == S_BUSY);
    StallM = (state_q == S_BUSY) | ((state_q == S_IDLE) & op_valid);
`ifdef MEM_ALIGN_CHECK_EN
    AdelM  = (state_q == S_IDLE) & MemReadM & ~FlushM & misaligned;
    AdesM  = (state_q == S_IDLE) & MemWriteM & ~FlushM & misaligned;
`else
    AdelM  = 1'b0;
    AdesM  = 1'b0;
`endif
  end

  assign ReadDataM = rdata_q;
  assign BusErrM   = bus_err_q;
  assign dwe       = dwe_q;
  assign daddr     = daddr_q;
  assign dbe       = dbe_q;
  assign dwdata    = dwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reset, sub-word loads/stores, timeout, flush, alignment and reset mid-transaction.
module tb_mem_access_unit;

  logic        clk, rst;
  logic        MemReadM, MemWriteM, MemSignedM, FlushM;
  logic [1:0]  MemSizeM;
  logic [31:0] AddrM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, AdelM, AdesM, BusErrM;
  logic        dreq, dwe, dack;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dbe;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.LAT_LIMIT(16)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
    .MemSignedM(MemSignedM), .AddrM(AddrM), .WriteDataM(WriteDataM),
    .FlushM(FlushM), .ReadDataM(ReadDataM), .StallM(StallM),
    .AdelM(AdelM), .AdesM(AdesM), .BusErrM(BusErrM),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dbe(dbe), .dwdata(dwdata),
    .dack(dack), .drdata(drdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    MemReadM = 0; MemWriteM = 0; MemSizeM = 2'b00; MemSignedM = 0;
    AddrM = 32'h0; WriteDataM = 32'h0; FlushM = 0;
  endtask

  task automatic present(input logic rd, input logic wr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    MemReadM = rd; MemWriteM = wr; MemSizeM = size; MemSignedM = sgn;
    AddrM = addr; WriteDataM = wd; FlushM = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL reset_dreq: got %b expected 0", dreq); end
    checks++; if (dbe !== 4'b0) begin errors++; $display("FAIL reset_dbe: got %b expected 0000", dbe); end
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", ReadDataM); end
    checks++; if (daddr !== 32'h0) begin errors++; $display("FAIL reset_daddr: got %h expected 00000000", daddr); end
    checks++; if (BusErrM !== 1'b0) begin errors++; $display("FAIL reset_buserr: got %b expected 0", BusErrM); end
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", StallM); end
  endtask

  task automatic test_load_byte_signed();
    @(negedge clk);
    present(1, 0, 2'b00, 1, 32'h0000_1003, 32'h0);
    #1;
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL lbs_stall_idle: got %b expected 1", StallM); end
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL lbs_dreq_idle: got %b expected 0", dreq); end
    @(negedge clk);
    checks++; if (dreq !== 1'b1) begin errors++; $display("FAIL lbs_dreq_busy: got %b expected 1", dreq); end
    checks++; if (dbe !== 4'b1000) begin errors++; $display("FAIL lbs_dbe: got %b expected 1000", dbe); end
    checks++; if (daddr !== 32'h0000_1000) begin errors++; $display("FAIL lbs_daddr: got %h expected 00001000", daddr); end
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL lbs_stall_busy: got %b expected 1", StallM); end
    dack = 1; drdata = 32'h80FF_FFFF;
    @(negedge clk);
    dack = 0;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL lbs_stall_done: got %b expected 0", StallM); end
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL lbs_dreq_done: got %b expected 0", dreq); end
    checks++; if (ReadDataM !== 32'hFFFF_FF80) begin errors++; $display("FAIL lbs_rdata: got %h expected ffffff80", ReadDataM); end
    checks++; if (BusErrM !== 1'b0) begin errors++; $display("FAIL lbs_buserr: got %b expected 0", BusErrM); end
    clear_inputs();
    @(negedge clk);
    checks++; if (dreq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL lbs_no_relaunch: got dreq=%b stall=%b expected 0 0", dreq, StallM); end
  endtask

  task automatic test_store_half();
    @(negedge clk);
    present(0, 1, 2'b01, 0, 32'h0000_2002, 32'h1234_ABCD);
    #1;
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL sh_stall_idle: got %b expected 1", StallM); end
    @(negedge clk);
    FlushM = 1;
    checks++; if (dwe !== 1'b1) begin errors++; $display("FAIL sh_dwe: got %b expected 1", dwe); end
    checks++; if (dbe !== 4'b1100) begin errors++; $display("FAIL sh_dbe: got %b expected 1100", dbe); end
    checks++; if (dwdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_dwdata: got %h expected abcdabcd", dwdata); end
    checks++; if (daddr !== 32'h0000_2000) begin errors++; $display("FAIL sh_daddr: got %h expected 00002000", daddr); end
    @(negedge clk);
    checks++; if (dreq !== 1'b1 || daddr !== 32'h0000_2000) begin errors++; $display("FAIL sh_hold: got dreq=%b daddr=%h expected 1 00002000", dreq, daddr); end
    dack = 1; drdata = 32'h5555_5555;
    @(negedge clk);
    dack = 0;
    checks++; if (ReadDataM !== 32'hFFFF_FF80) begin errors++; $display("FAIL sh_rdata_kept: got %h expected ffffff80", ReadDataM); end
    checks++; if (dreq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL sh_done: got dreq=%b stall=%b expected 0 0", dreq, StallM); end
    clear_inputs();
    @(negedge clk);
  endtask

  typedef struct {
    logic        rd, wr, sgn;
    logic [1:0]  size;
    logic [31:0] addr, wd, rdat, exp_addr, exp_wd, exp_rd;
    logic [3:0]  exp_be;
  } vec_t;

  task automatic test_subword();
    vec_t v [7];
    v[0] = '{1, 0, 0, 2'b00, 32'h1001, 32'h0,        32'h1234_8056, 32'h1000, 32'h0,        32'h0000_0080, 4'b0010};
    v[1] = '{1, 0, 1, 2'b01, 32'h0022, 32'h0,        32'h8001_7FFF, 32'h0020, 32'h0,        32'hFFFF_8001, 4'b1100};
    v[2] = '{0, 1, 0, 2'b00, 32'h0003, 32'h0000_00A5, 32'h0,        32'h0000, 32'hA5A5_A5A5, 32'hFFFF_8001, 4'b1000};
    v[3] = '{1, 0, 0, 2'b01, 32'h0100, 32'h0,        32'h1234_F00D, 32'h0100, 32'h0,        32'h0000_F00D, 4'b0011};
    v[4] = '{1, 0, 1, 2'b00, 32'h0002, 32'h0,        32'h007F_0000, 32'h0000, 32'h0,        32'h0000_007F, 4'b0100};
    v[5] = '{1, 0, 0, 2'b11, 32'h0044, 32'h0,        32'hDEAD_BEEF, 32'h0044, 32'h0,        32'hDEAD_BEEF, 4'b1111};
    v[6] = '{0, 1, 0, 2'b10, 32'h0048, 32'h0102_0304, 32'h0,        32'h0048, 32'h0102_0304, 32'hDEAD_BEEF, 4'b1111};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      present(v[i].rd, v[i].wr, v[i].size, v[i].sgn, v[i].addr, v[i].wd);
      @(negedge clk);
      checks++; if (dbe !== v[i].exp_be || daddr !== v[i].exp_addr || dwe !== v[i].wr)
        begin errors++; $display("FAIL sub%0d_bus: got be=%b addr=%h we=%b expected %b %h %b", i, dbe, daddr, dwe, v[i].exp_be, v[i].exp_addr, v[i].wr); end
      if (v[i].wr) begin
        checks++; if (dwdata !== v[i].exp_wd) begin errors++; $display("FAIL sub%0d_dwdata: got %h expected %h", i, dwdata, v[i].exp_wd); end
      end
      dack = 1; drdata = v[i].rdat;
      @(negedge clk);
      dack = 0;
      checks++; if (ReadDataM !== v[i].exp_rd) begin errors++; $display("FAIL sub%0d_rdata: got %h expected %h", i, ReadDataM, v[i].exp_rd); end
      clear_inputs();
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    @(negedge clk);
    present(1, 0, 2'b10, 0, 32'h0000_0040, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dreq) n++;
      else break;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL to_busy_cycles: got %0d expected 16", n); end
    checks++; if (BusErrM !== 1'b1) begin errors++; $display("FAIL to_buserr: got %b expected 1", BusErrM); end
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h expected 00000000", ReadDataM); end
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL to_stall: got %b expected 0", StallM); end
    clear_inputs();
    dack = 1; drdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dack = 0;
    checks++; if (BusErrM !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b expected 0", BusErrM); end
    checks++; if (ReadDataM !== 32'h0 || dreq !== 1'b0) begin errors++; $display("FAIL to_late_dack: got rdata=%h dreq=%b expected 0 0", ReadDataM, dreq); end
  endtask

  task automatic test_timeout_race();
    int n = 0;
    @(negedge clk);
    present(1, 0, 2'b10, 0, 32'h0000_0050, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!dreq) break;
      n++;
      if (n == 16) begin dack = 1; drdata = 32'h1357_9BDF; end
    end
    dack = 0;
    checks++; if (n !== 16) begin errors++; $display("FAIL race_cycles: got %0d expected 16", n); end
    checks++; if (BusErrM !== 1'b0) begin errors++; $display("FAIL race_buserr: got %b expected 0", BusErrM); end
    checks++; if (ReadDataM !== 32'h1357_9BDF) begin errors++; $display("FAIL race_rdata: got %h expected 13579bdf", ReadDataM); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_flush();
    @(negedge clk);
    present(1, 0, 2'b10, 0, 32'h0000_0060, 32'h0);
    FlushM = 1;
    #1;
    checks++; if (StallM !== 1'b0 || AdelM !== 1'b0) begin errors++; $display("FAIL fl_idle: got stall=%b adel=%b expected 0 0", StallM, AdelM); end
    @(negedge clk);
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL fl_dreq: got %b expected 0", dreq); end
    checks++; if (ReadDataM !== 32'h1357_9BDF) begin errors++; $display("FAIL fl_rdata: got %h expected 13579bdf", ReadDataM); end
    clear_inputs();
  endtask

  task automatic test_dack_idle();
    @(negedge clk);
    dack = 1; drdata = 32'hBAD0_BAD0;
    @(negedge clk);
    dack = 0;
    checks++; if (ReadDataM !== 32'h1357_9BDF || dreq !== 1'b0 || BusErrM !== 1'b0)
      begin errors++; $display("FAIL dack_idle: got rdata=%h dreq=%b berr=%b expected 13579bdf 0 0", ReadDataM, dreq, BusErrM); end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    present(1, 0, 2'b10, 0, 32'h0000_3002, 32'h0);
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    checks++; if (AdelM !== 1'b1 || AdesM !== 1'b0 || StallM !== 1'b0)
      begin errors++; $display("FAIL mis_lw: got adel=%b ades=%b stall=%b expected 1 0 0", AdelM, AdesM, StallM); end
    @(negedge clk);
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL mis_lw_dreq: got %b expected 0", dreq); end
    present(0, 1, 2'b01, 0, 32'h0000_3001, 32'h0);
    #1;
    checks++; if (AdesM !== 1'b1 || AdelM !== 1'b0 || StallM !== 1'b0)
      begin errors++; $display("FAIL mis_sh: got ades=%b adel=%b stall=%b expected 1 0 0", AdesM, AdelM, StallM); end
    @(negedge clk);
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL mis_sh_dreq: got %b expected 0", dreq); end
    clear_inputs();
`else
    checks++; if (AdelM !== 1'b0 || StallM !== 1'b1) begin errors++; $display("FAIL mis_lw: got adel=%b stall=%b expected 0 1", AdelM, StallM); end
    @(negedge clk);
    checks++; if (daddr !== 32'h0000_3000 || dbe !== 4'b1111)
      begin errors++; $display("FAIL mis_lw_bus: got addr=%h be=%b expected 00003000 1111", daddr, dbe); end
    dack = 1; drdata = 32'h1122_3344;
    @(negedge clk);
    dack = 0;
    checks++; if (ReadDataM !== 32'h1122_3344) begin errors++; $display("FAIL mis_lw_rdata: got %h expected 11223344", ReadDataM); end
    clear_inputs();
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    present(1, 0, 2'b10, 0, 32'h0000_0080, 32'h0);
    @(negedge clk);
    checks++; if (dreq !== 1'b1) begin errors++; $display("FAIL rb_busy: got %b expected 1", dreq); end
    rst = 0;
    #1;
    checks++; if (dreq !== 1'b0 || daddr !== 32'h0 || dbe !== 4'b0)
      begin errors++; $display("FAIL rb_abandon: got dreq=%b addr=%h be=%b expected 0 0 0", dreq, daddr, dbe); end
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL rb_rdata: got %h expected 00000000", ReadDataM); end
    clear_inputs();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    present(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    checks++; if (dreq !== 1'b1 || daddr !== 32'h0000_0010 || dbe !== 4'b1111)
      begin errors++; $display("FAIL rb_new_bus: got dreq=%b addr=%h be=%b expected 1 00000010 1111", dreq, daddr, dbe); end
    dack = 1; drdata = 32'hCAFE_BABE;
    @(negedge clk);
    dack = 0;
    checks++; if (ReadDataM !== 32'hCAFE_BABE || StallM !== 1'b0)
      begin errors++; $display("FAIL rb_new_done: got rdata=%h stall=%b expected cafebabe 0", ReadDataM, StallM); end
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst = 0; dack = 0; drdata = 32'h0;
    clear_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1;
    test_load_byte_signed();
    test_store_half();
    test_subword();
    test_timeout();
    test_timeout_race();
    test_flush();
    test_dack_idle();
    test_misalign();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
